// File: rtl/psubsb_seq.sv
// Sequential packed saturating subtractor: one signed 4-bit lane per clock, lane 0 first.
// Define PSUBSB_ADD_EN to add an op input selecting packed saturating add (op=1) or subtract (op=0).
module psubsb_seq #(
    parameter int unsigned NUM_LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
`ifdef PSUBSB_ADD_EN
    input  logic                     op,
`endif
    input  logic [4*NUM_LANES-1:0]   A,
    input  logic [4*NUM_LANES-1:0]   B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4*NUM_LANES-1:0]   RES,
    output logic [NUM_LANES-1:0]     ovfl_lanes
);

    localparam int unsigned DATA_W = 4 * NUM_LANES;
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_nxt;
    logic [LANE_W-1:0]   lane_q, lane_nxt;
    logic [DATA_W-1:0]   a_q, a_nxt;
    logic [DATA_W-1:0]   b_q, b_nxt;
    logic [DATA_W-1:0]   res_q, res_nxt;
    logic [NUM_LANES-1:0] ovfl_q, ovfl_nxt;
    logic                in_ready_q, in_ready_nxt;
    logic                out_valid_q, out_valid_nxt;
    logic                add_q, add_nxt;

    logic [3:0]          lane_a, lane_b;
    logic [4:0]          lane_sum;
    logic [3:0]          lane_sat;
    logic                lane_clamp;

`ifdef PSUBSB_ADD_EN
    logic add_in;
    assign add_in = op;
`else
    logic add_in;
    assign add_in = 1'b0;
`endif

    // Per-lane datapath: 5-bit exact result, then clamp to the signed 4-bit range.
    always_comb begin
        lane_a     = a_q[lane_q*4 +: 4];
        lane_b     = b_q[lane_q*4 +: 4];
        lane_sum   = '0;
        lane_sat   = '0;
        lane_clamp = 1'b0;
        if (add_q) begin
            lane_sum = {lane_a[3], lane_a} + {lane_b[3], lane_b};
        end else begin
            lane_sum = {lane_a[3], lane_a} - {lane_b[3], lane_b};
        end
        // Bits [4:3] disagree only when the value left the range -8..7.
        if (!lane_sum[4] && lane_sum[3]) begin
            lane_sat   = 4'h7;
            lane_clamp = 1'b1;
        end else if (lane_sum[4] && !lane_sum[3]) begin
            lane_sat   = 4'h8;
            lane_clamp = 1'b1;
        end else begin
            lane_sat   = lane_sum[3:0];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state_q;
        lane_nxt      = lane_q;
        a_nxt         = a_q;
        b_nxt         = b_q;
        add_nxt       = add_q;
        res_nxt       = res_q;
        ovfl_nxt      = ovfl_q;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_nxt     = A;
                    b_nxt     = B;
                    add_nxt   = add_in;
                    res_nxt   = '0;
                    ovfl_nxt  = '0;
                    lane_nxt  = '0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                res_nxt[lane_q*4 +: 4] = lane_sat;
                ovfl_nxt[lane_q]       = lane_clamp;
                lane_nxt               = LANE_W'(lane_q + 1'b1);
                if (lane_q == LAST_LANE) begin
                    lane_nxt  = '0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            add_q       <= 1'b0;
            res_q       <= '0;
            ovfl_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            lane_q      <= lane_nxt;
            a_q         <= a_nxt;
            b_q         <= b_nxt;
            add_q       <= add_nxt;
            res_q       <= res_nxt;
            ovfl_q      <= ovfl_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign RES        = res_q;
    assign ovfl_lanes = ovfl_q;

endmodule

// File: tb/tb_psubsb_seq.sv
// Randomized self-checking bench for psubsb_seq against a lane-arithmetic reference model.
module tb_psubsb_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] RES;
    logic [3:0]  ovfl_lanes;
    logic        op;

    int total;
    int bad;

    psubsb_seq #(.NUM_LANES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef PSUBSB_ADD_EN
        .op         (op),
`endif
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .RES        (RES),
        .ovfl_lanes (ovfl_lanes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovfl[3:0], res[15:0]} from plain integer lane arithmetic.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic add);
        logic [15:0] r;
        logic [3:0]  ov;
        logic [3:0]  na;
        logic [3:0]  nb;
        int          x;
        int          y;
        int          d;
        r  = '0;
        ov = '0;
        for (int i = 0; i < 4; i++) begin
            na = a[i*4 +: 4];
            nb = b[i*4 +: 4];
            x  = na[3] ? int'(na) - 16 : int'(na);
            y  = nb[3] ? int'(nb) - 16 : int'(nb);
            d  = add ? x + y : x - y;
            if (d > 7) begin
                d = 7;
                ov[i] = 1'b1;
            end else if (d < -8) begin
                d = -8;
                ov[i] = 1'b1;
            end
            r[i*4 +: 4] = 4'(d);
        end
        return {ov, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accepting edge, then count clocks until out_valid.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic add, output int lat);
        A        = a;
        B        = b;
        op       = add;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (out_valid) lat = lat - 1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic add, input logic [15:0] exp_res, input logic [3:0] exp_ov);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        launch(a, b, add, lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_res"}, 32'(RES), 32'(exp_res));
        check({tag, "_ovfl"}, 32'(ovfl_lanes), 32'(exp_ov));
        check({tag, "_model"}, 32'({ovfl_lanes, RES}), 32'(model(a, b, add)));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ir_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] hold_res;
        logic [19:0] exp_v;
        int          lat;
        int          n;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        op        = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", 32'(RES), 32'd0);
        check("rst_ovfl", 32'(ovfl_lanes), 32'd0);

        run_op("basic", 16'h1234, 16'h1111, 1'b0, 16'h0123, 4'b0000);
        run_op("sat", 16'h78F0, 16'h8170, 1'b0, 16'h7880, 4'b1100);
        run_op("negsat", 16'h8080, 16'h7F7F, 1'b0, 16'h8181, 4'b1010);

        // Backpressure: result must hold while out_ready stays low.
        launch(16'h5A3C, 16'hC3A5, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd4);
        exp_v    = model(16'h5A3C, 16'hC3A5, 1'b0);
        hold_res = RES;
        check("bp_res", 32'(RES), 32'(exp_v[15:0]));
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_res", 32'(RES), 32'(hold_res));
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset two clocks after acceptance discards the partial result.
        A        = 16'h7777;
        B        = 16'h8888;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_res", 32'(RES), 32'd0);
        check("midrst_ovfl", 32'(ovfl_lanes), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        run_op("post_rst", 16'h7777, 16'h8888, 1'b0, 16'h7777, 4'b1111);

`ifdef PSUBSB_ADD_EN
        run_op("add_sat", 16'h7777, 16'h1111, 1'b1, 16'h7777, 4'b1111);
        run_op("add_basic", 16'h1234, 16'h1111, 1'b1, 16'h2345, 4'b0000);
`endif

        // Back-to-back random traffic with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (!in_ready && n < 10) begin
                step();
                n++;
            end
            ra = 16'($urandom);
            rb = 16'($urandom);
            A  = ra;
            B  = rb;
`ifdef PSUBSB_ADD_EN
            op = 1'($urandom);
`else
            op = 1'b0;
`endif
            exp_v = model(ra, rb, op);
            step();
            lat = 1;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            check("b2b_latency", 32'(lat), 32'd5);
            check("b2b_result", 32'({ovfl_lanes, RES}), 32'(exp_v));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
